// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_pkg                                                   |
// | Shared state enum, opcode and ALU encodings for the multicycle control.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    FAULT    = 4'd11
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [2:0] c_alu_add  = 3'b000;
  localparam logic [2:0] c_alu_sub  = 3'b001;
  localparam logic [2:0] c_alu_and  = 3'b010;
  localparam logic [2:0] c_alu_or   = 3'b011;
  localparam logic [2:0] c_alu_sltu = 3'b100;
  localparam logic [2:0] c_alu_slt  = 3'b101;
  localparam logic [2:0] c_alu_sll  = 3'b110;
  localparam logic [2:0] c_alu_srl  = 3'b111;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       adrSrc;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic       fault;
  } ctrl_t;

  // Moore control word for a state; alu is the decoded op for EXECR/EXECI/BRANCH.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] alu);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.aluSrcB = 2'b10; c.resultSrc = 2'b10; end
      DECODE:   begin c.aluSrcA = 2'b01; c.aluSrcB = 2'b01; end
      MEMADR:   begin c.aluSrcA = 2'b10; c.aluSrcB = 2'b01; end
      MEMREAD:  c.adrSrc = 1'b1;
      MEMWB:    begin c.resultSrc = 2'b01; c.regWrite = 1'b1; end
      MEMWRITE: begin c.adrSrc = 1'b1; c.memWrite = 1'b1; end
      EXECR:    begin c.aluSrcA = 2'b10; c.aluControl = alu; end
      EXECI:    begin c.aluSrcA = 2'b10; c.aluSrcB = 2'b01; c.aluControl = alu; end
      ALUWB:    c.regWrite = 1'b1;
      BRANCH:   begin c.aluSrcA = 2'b10; c.aluControl = alu; end
      JAL:      begin c.aluSrcA = 2'b01; c.aluSrcB = 2'b10; end
      FAULT:    c.fault = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_decoder                                                              |
// | Maps aluOp/funct3/funct7b5/op[5] to an ALU operation and illegal flag.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] aluControl,
  output logic       illegal
);

  always_comb begin
    aluControl = c_alu_add;
    illegal    = 1'b0;
    case (aluOp)
      c_aluop_sub: aluControl = c_alu_sub;
      c_aluop_funct: begin
        case (funct3)
          3'b000: aluControl = (op5 && funct7b5) ? c_alu_sub : c_alu_add;
          3'b111: aluControl = c_alu_and;
          3'b110: aluControl = c_alu_or;
          3'b011: aluControl = c_alu_sltu;
          3'b010: aluControl = c_alu_slt;
          3'b001: aluControl = c_alu_sll;
          // Shift right: funct7b5 set selects the arithmetic form, flagged illegal.
          3'b101: begin aluControl = c_alu_srl; illegal = funct7b5; end
          default: illegal = 1'b1;
        endcase
      end
      default: aluControl = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control                                                       |
// | Multicycle RISC-V control FSM with memReady timeout and sticky fault.    |
// | Optional macro BRANCH_NE_EN adds bne support in the BRANCH state.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       adrSrc,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic       fault,
  output logic [3:0] stateOut
);

  localparam logic [8:0] c_timeout = 9'(TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic [7:0] r_cnt;
  logic       r_illegal;
  logic [1:0] w_aluop;
  logic [2:0] w_aluctl;
  logic       w_illegal;
  logic       w_timeout;
  logic       w_waiting;
  logic       w_br_ok;
  logic       w_br_take;

`ifdef BRANCH_NE_EN
  assign w_br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign w_br_take = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
`else
  assign w_br_ok   = (funct3 == 3'b000);
  assign w_br_take = (funct3 == 3'b000) && zero;
`endif

  assign w_waiting = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);
  // Fault on the wait cycle that would bring the count up to TIMEOUT.
  assign w_timeout = (({1'b0, r_cnt} + 9'd1) == c_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    if (memReady) w_next = DECODE; else if (w_timeout) w_next = FAULT;
      DECODE: begin
        case (op)
          c_op_load, c_op_store: w_next = MEMADR;
          c_op_rtype:            w_next = EXECR;
          c_op_itype:            w_next = EXECI;
          c_op_branch:           w_next = w_br_ok ? BRANCH : FAULT;
          c_op_jal:              w_next = JAL;
          default:               w_next = FAULT;
        endcase
      end
      MEMADR:   w_next = (op == c_op_load) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (memReady) w_next = MEMWB; else if (w_timeout) w_next = FAULT;
      MEMWB:    w_next = FETCH;
      MEMWRITE: if (memReady) w_next = FETCH; else if (w_timeout) w_next = FAULT;
      EXECR, EXECI: w_next = r_illegal ? FAULT : ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      JAL:      w_next = ALUWB;
      FAULT:    w_next = FAULT;
      default:  w_next = FAULT;
    endcase
  end

  // ALU op is decoded for the state being entered so it can be registered.
  always_comb begin
    w_aluop = c_aluop_add;
    if (w_next == EXECR || w_next == EXECI) w_aluop = c_aluop_funct;
    else if (w_next == BRANCH)              w_aluop = c_aluop_sub;
  end

  alu_decoder u_alu_decoder (
    .aluOp      (w_aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .aluControl (w_aluctl),
    .illegal    (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_ctrl    <= ctrl_of(FETCH, c_alu_add);
      r_cnt     <= 8'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= ctrl_of(w_next, w_aluctl);
      r_illegal <= w_illegal;
      if (w_next != r_state)
        r_cnt <= 8'd0;
      else if (w_waiting && !memReady)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign irWrite    = (r_state == FETCH) && memReady;
  assign pcWrite    = irWrite || (r_state == JAL) || ((r_state == BRANCH) && w_br_take);
  assign regWrite   = r_ctrl.regWrite;
  assign memWrite   = r_ctrl.memWrite;
  assign adrSrc     = r_ctrl.adrSrc;
  assign resultSrc  = r_ctrl.resultSrc;
  assign aluSrcA    = r_ctrl.aluSrcA;
  assign aluSrcB    = r_ctrl.aluSrcB;
  assign aluControl = r_ctrl.aluControl;
  assign fault      = r_ctrl.fault;
  assign stateOut   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control                                                    |
// | Directed table, corner sequences and random instructions vs a model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;

  localparam int TMO = 15;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_FAULT = 4'd11;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_SYS = 7'b1110011;
  localparam logic [18:0] MASK_ALL = 19'h7FFFF;
  localparam logic [18:0] MASK_NOALU = 19'h7FFF1;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, memReady;
  logic       pcWrite, irWrite, regWrite, memWrite, adrSrc, fault;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] aluControl;
  logic [3:0] stateOut;
  logic [18:0] dut_vec;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [3:0] st; logic mr; } ph_t;
  ph_t mq[$];

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic z;
    int cyc; logic [2:0] alu; logic chk_alu; logic pc; logic flt;
  } vec_t;
  vec_t tbl[$];

  multicycle_control #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite), .regWrite(regWrite),
    .memWrite(memWrite), .adrSrc(adrSrc), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .fault(fault), .stateOut(stateOut)
  );

  always #5 clk = ~clk;

  assign dut_vec = {stateOut, pcWrite, irWrite, regWrite, memWrite, adrSrc,
                    resultSrc, aluSrcA, aluSrcB, aluControl, fault};

  function automatic bit illegal_f(input logic [2:0] f3, input logic f7);
    return (f3 == 3'd4) || (f3 == 3'd5 && f7);
  endfunction

  function automatic bit br_ok(input logic [2:0] f3);
`ifdef BRANCH_NE_EN
    return (f3 == 3'd0) || (f3 == 3'd1);
`else
    return f3 == 3'd0;
`endif
  endfunction

  function automatic logic br_take(input logic [2:0] f3, input logic z);
`ifdef BRANCH_NE_EN
    return ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
`else
    return (f3 == 3'd0) && z;
`endif
  endfunction

  function automatic logic [2:0] alu_exec(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [2:0] t [8];
    t = '{3'd0, 3'd6, 3'd5, 3'd4, 3'd0, 3'd7, 3'd3, 3'd2};
    if (f3 == 3'd0 && is_r && f7) return 3'd1;
    return t[f3];
  endfunction

  // Expected {state, enables, selects, aluControl, fault} from the per-state table.
  function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic [2:0] f3,
                                          input logic f7, input logic mr, input logic z);
    logic pw, iw, rw, mw, as, f;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    {pw, iw, rw, mw, as, f} = 6'b0;
    rs = 2'd0; a = 2'd0; b = 2'd0; alu = 3'd0;
    case (st)
      S_FETCH:    begin b = 2'd2; rs = 2'd2; iw = mr; pw = mr; end
      S_DECODE:   begin a = 2'd1; b = 2'd1; end
      S_MEMADR:   begin a = 2'd2; b = 2'd1; end
      S_MEMREAD:  as = 1'b1;
      S_MEMWB:    begin rs = 2'd1; rw = 1'b1; end
      S_MEMWRITE: begin as = 1'b1; mw = 1'b1; end
      S_EXECR:    begin a = 2'd2; alu = alu_exec(f3, f7, 1'b1); end
      S_EXECI:    begin a = 2'd2; b = 2'd1; alu = alu_exec(f3, f7, 1'b0); end
      S_ALUWB:    rw = 1'b1;
      S_BRANCH:   begin a = 2'd2; alu = 3'd1; pw = br_take(f3, z); end
      S_JAL:      begin a = 2'd1; b = 2'd2; pw = 1'b1; end
      S_FAULT:    f = 1'b1;
      default:    f = 1'b0;
    endcase
    return {st, pw, iw, rw, mw, as, rs, a, b, alu, f};
  endfunction

  task automatic check_vec(input string name, input logic [18:0] exp, input logic [18:0] mask);
    checks++;
    if ((dut_vec & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h (mask %h)", name, $time, dut_vec, exp, mask);
    end
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; memReady = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns 1 if the wait phase exhausts the timeout and ends in FAULT.
  function automatic bit push_wait(input logic [3:0] st, input int w);
    int n;
    n = (w >= TMO) ? TMO : w;
    for (int i = 0; i < n; i++) mq.push_back(ph_t'{st, 1'b0});
    if (w >= TMO) begin
      mq.push_back(ph_t'{S_FAULT, 1'($urandom_range(0, 1))});
      return 1'b1;
    end
    mq.push_back(ph_t'{st, 1'b1});
    return 1'b0;
  endfunction

  function automatic void push_one(input logic [3:0] st);
    mq.push_back(ph_t'{st, 1'($urandom_range(0, 1))});
  endfunction

  // Instruction-level model: the list of phases an instruction walks through.
  function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input int fw, input int mw);
    mq.delete();
    if (push_wait(S_FETCH, fw)) return;
    push_one(S_DECODE);
    case (o)
      OP_LW:  begin push_one(S_MEMADR); if (!push_wait(S_MEMREAD, mw)) push_one(S_MEMWB); end
      OP_SW:  begin push_one(S_MEMADR); void'(push_wait(S_MEMWRITE, mw)); end
      OP_R:   begin push_one(S_EXECR); push_one(illegal_f(f3, f7) ? S_FAULT : S_ALUWB); end
      OP_I:   begin push_one(S_EXECI); push_one(illegal_f(f3, f7) ? S_FAULT : S_ALUWB); end
      OP_BR:  push_one(br_ok(f3) ? S_BRANCH : S_FAULT);
      OP_JAL: begin push_one(S_JAL); push_one(S_ALUWB); end
      default: push_one(S_FAULT);
    endcase
  endfunction

  task automatic run_model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw);
    logic [3:0] st;
    logic [18:0] m;
    build(o, f3, f7, fw, mw);
    for (int i = 0; i < mq.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin op = o; funct3 = f3; funct7b5 = f7; end
      memReady = mq[i].mr; zero = 1'($urandom_range(0, 1)); #1;
      st = mq[i].st;
      m = ((st == S_EXECR || st == S_EXECI) && illegal_f(f3, f7)) ? MASK_NOALU : MASK_ALL;
      check_vec("model", exp_vec(st, f3, f7, memReady, zero), m);
    end
    if (mq[mq.size() - 1].st == S_FAULT) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        memReady = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1)); #1;
        check_vec("fault_hold", exp_vec(S_FAULT, f3, f7, memReady, zero), MASK_ALL);
      end
      do_reset();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int alu, pc, flt;
    cyc = 0; alu = 0; pc = 0; flt = 0;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      memReady = 1'b1; zero = v.z; #1;
      if (k > 0 && stateOut == S_FETCH) break;
      cyc++;
      if (k == 2) alu = int'(aluControl);
      if (k > 0 && pcWrite) pc = 1;
      if (fault) begin flt = 1; break; end
    end
    chk("tbl_cycles", idx, cyc, v.cyc);
    if (v.chk_alu) chk("tbl_alu", idx, alu, int'(v.alu));
    chk("tbl_pcwrite", idx, pc, int'(v.pc));
    chk("tbl_fault", idx, flt, int'(v.flt));
    do_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] o;
    int c, fw, mw;
    rst = 1'b1; op = OP_R; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; memReady = 1'b0;
    #1;
    check_vec("reset_state", exp_vec(S_FETCH, 3'd0, 1'b0, 1'b0, 1'b0), MASK_ALL);
    @(posedge clk); #1;
    rst = 1'b0;

    // op, f3, f7b5, zero, cycles, alu (third cycle), chk_alu, pcWrite after FETCH, fault
    tbl.push_back(vec_t'{OP_R,   3'd0, 1'b0, 1'b0, 4, 3'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_R,   3'd0, 1'b1, 1'b0, 4, 3'd1, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_R,   3'd7, 1'b0, 1'b0, 4, 3'd2, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_R,   3'd6, 1'b0, 1'b0, 4, 3'd3, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_R,   3'd3, 1'b0, 1'b0, 4, 3'd4, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_R,   3'd2, 1'b0, 1'b0, 4, 3'd5, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_R,   3'd1, 1'b0, 1'b0, 4, 3'd6, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_R,   3'd5, 1'b0, 1'b0, 4, 3'd7, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_I,   3'd0, 1'b1, 1'b0, 4, 3'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_LW,  3'd2, 1'b0, 1'b0, 5, 3'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_SW,  3'd2, 1'b0, 1'b0, 4, 3'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_BR,  3'd0, 1'b0, 1'b1, 3, 3'd1, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{OP_BR,  3'd0, 1'b0, 1'b0, 3, 3'd1, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{OP_JAL, 3'd0, 1'b0, 1'b0, 4, 3'd0, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{OP_SYS, 3'd0, 1'b0, 1'b0, 3, 3'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back(vec_t'{OP_R,   3'd4, 1'b0, 1'b0, 4, 3'd0, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{OP_I,   3'd5, 1'b1, 1'b0, 4, 3'd0, 1'b0, 1'b0, 1'b1});
`ifdef BRANCH_NE_EN
    tbl.push_back(vec_t'{OP_BR,  3'd1, 1'b0, 1'b0, 3, 3'd1, 1'b1, 1'b1, 1'b0});
`else
    tbl.push_back(vec_t'{OP_BR,  3'd1, 1'b0, 1'b0, 3, 3'd0, 1'b1, 1'b0, 1'b1});
`endif
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Wait-counter boundaries and multi-cycle memory accesses.
    run_model(OP_R,  3'd0, 1'b0, TMO - 1, 0);
    run_model(OP_R,  3'd0, 1'b0, TMO, 0);
    run_model(OP_LW, 3'd2, 1'b0, 0, 3);
    run_model(OP_LW, 3'd2, 1'b0, 0, TMO - 1);
    run_model(OP_LW, 3'd2, 1'b0, 0, TMO);
    run_model(OP_SW, 3'd2, 1'b0, 2, TMO);
    run_model(OP_SYS, 3'd0, 1'b0, 0, 0);

    // Asynchronous reset in EXECR abandons the write-back.
    op = OP_R; funct3 = 3'd0; funct7b5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); memReady = 1'b1; #1;
    end
    check_vec("execr_before_rst", exp_vec(S_EXECR, 3'd0, 1'b0, 1'b1, zero), MASK_ALL);
    #1 rst = 1'b1; memReady = 1'b0;
    #1 check_vec("async_rst", exp_vec(S_FETCH, 3'd0, 1'b0, 1'b0, zero), MASK_ALL);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); memReady = 1'b0; #1;
      check_vec("after_rst", exp_vec(S_FETCH, 3'd0, 1'b0, 1'b0, zero), MASK_ALL);
    end
    do_reset();

    for (int n = 0; n < 80; n++) begin
      c = $urandom_range(0, 7);
      case (c)
        0, 7: o = OP_R;
        1: o = OP_I;
        2: o = OP_LW;
        3: o = OP_SW;
        4: o = OP_BR;
        5: o = OP_JAL;
        default: o = ($urandom_range(0, 1) == 0) ? OP_SYS : 7'b0110111;
      endcase
      fw = $urandom_range(0, 4);
      mw = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) fw = $urandom_range(TMO - 2, TMO + 1);
      if ($urandom_range(0, 9) == 0) mw = $urandom_range(TMO - 2, TMO + 1);
      run_model(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), fw, mw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum wait cycles on memReady before fault (1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU result-equals-zero flag.
REQ-008 memReady  input  1  memory access complete this cycle.
REQ-009 pcWrite, irWrite, regWrite, memWrite, adrSrc  output  1 each  datapath enables/selects.
REQ-010 resultSrc, aluSrcA, aluSrcB  output  2 each  datapath mux selects.
REQ-011 aluControl  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 sltu, 101 slt, 110 sll, 111 srl.
REQ-012 fault  output  1  sticky illegal-instruction/timeout indicator.
REQ-013 stateOut  output  4  current state encoding, for debug.

Function
REQ-014 FSM states SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, FAULT.
REQ-015 FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluControl=000, resultSrc=10; irWrite=pcWrite=memReady; advance to DECODE only when memReady=1.
REQ-016 DECODE: aluSrcA=01, aluSrcB=01, add; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, other->FAULT.
REQ-017 MEMADR: aluSrcA=10, aluSrcB=01, add; next MEMREAD for load, MEMWRITE for store.
REQ-018 MEMREAD: adrSrc=1, resultSrc=00; hold until memReady=1, then MEMWB.
REQ-019 MEMWB: resultSrc=01, regWrite=1; next FETCH.
REQ-020 MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1 while waiting; on memReady=1 go to FETCH.
REQ-021 EXECR: aluSrcA=10, aluSrcB=00; EXECI: aluSrcA=10, aluSrcB=01; both next ALUWB.
REQ-022 ALU decode in EXECR/EXECI by funct3: 000 add (sub if EXECR and funct7b5=1), 111 and, 110 or, 011 sltu, 010 slt, 001 sll, 101 srl; funct3 100 or (101 with funct7b5=1) SHALL go to FAULT instead of ALUWB.
REQ-023 ALUWB: resultSrc=00, regWrite=1; next FETCH.
REQ-024 BRANCH: aluSrcA=10, aluSrcB=00, sub, resultSrc=00; pcWrite=zero when funct3=000; next FETCH.
REQ-025 JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1; next ALUWB.
REQ-026 Outputs not listed for a state SHALL be 0; all outputs Moore except memReady/zero-qualified enables.
REQ-027 Wait counter (8-bit) SHALL clear on entry to FETCH/MEMREAD/MEMWRITE, increment each cycle memReady=0 there; reaching TIMEOUT SHALL enter FAULT.
REQ-028 memReady=1 on the cycle the counter reaches TIMEOUT SHALL take the normal transition.
REQ-029 FAULT: all enables 0, fault=1, held until rst.

Reset
REQ-030 rst SHALL asynchronously force state FETCH, counter 0, fault 0; outputs then take FETCH values.
REQ-031 rst asserted mid-instruction SHALL abandon it with no further regWrite/memWrite.

Configuration
REQ-032 Macro BRANCH_NE_EN: defined -> BRANCH with funct3=001 sets pcWrite=~zero; undefined -> funct3 other than 000 in DECODE for op 1100011 goes to FAULT.

Structure
REQ-033 Shared package SHALL hold the state enum, opcode constants and aluControl encodings.
REQ-034 Sub-module alu_decoder SHALL map (aluOp, funct3, funct7b5, op[5]) to aluControl and illegal flag, combinational.

Verification
REQ-035 add x3,x1,x2 (op 0110011, f3 000, f7b5 0), memReady=1 -> FETCH,DECODE,EXECR(aluControl 000),ALUWB(regWrite=1),FETCH: 4 cycles.
REQ-036 lw with memReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, regWrite=1 only in MEMWB.
REQ-037 beq with zero=1 -> pcWrite=1 in BRANCH; zero=0 -> pcWrite=0.
REQ-038 op 1110011 -> FAULT after DECODE, fault=1 persists until rst.
REQ-039 memReady held 0 in FETCH, TIMEOUT=15 -> FAULT entered after 15 wait cycles; rst mid-EXECR -> FETCH, no regWrite.
